// File: rtl/serial_sum_collector.sv
// Serial-in, parallel-out collector for the LSB-first serial adder output.
// Optional macro SERIAL_SUM_CARRY_EN: when defined, o_cout captures the final carry; otherwise o_cout is 0.
module serial_sum_collector #(
    parameter int N = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic         i_bit_vld,
    input  logic         i_sum_bit,
    input  logic         i_carry,
    input  logic         i_rdy,
    output logic [N-1:0] o_sum,
    output logic         o_cout,
    output logic         o_vld,
    output logic         o_busy,
    output logic         o_ovf
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [N-1:0]    shreg_reg;
    logic [N-1:0]    sum_reg;
    logic [CW-1:0]   count_reg;
    logic            ovf_reg;

    logic            start_en;
    logic            shift_en;
    logic            drop_en;
    logic            last_bit;
    logic [N-1:0]    shift_word;
    logic [N-1:0]    first_word;

    assign last_bit   = (count_reg == CW'(N - 1));
    assign shift_word = {i_sum_bit, shreg_reg[N-1:1]};
    assign first_word = {i_sum_bit, {(N-1){1'b0}}};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A start in COLLECT restarts the word and stays in COLLECT.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (i_start) state_next = COLLECT;
            COLLECT: if (!i_start && i_bit_vld && last_bit) state_next = HOLD;
            HOLD:    if (i_rdy) state_next = i_start ? COLLECT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_vld    = 1'b0;
        o_busy   = 1'b0;
        start_en = 1'b0;
        shift_en = 1'b0;
        drop_en  = 1'b0;
        case (state_reg)
            IDLE: begin
                start_en = i_start;
            end
            COLLECT: begin
                o_busy   = 1'b1;
                start_en = i_start;
                shift_en = !i_start && i_bit_vld;
            end
            HOLD: begin
                o_vld    = 1'b1;
                start_en = i_start && i_rdy;
                drop_en  = !i_rdy && (i_start || i_bit_vld);
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shreg_reg <= '0;
            count_reg <= '0;
            sum_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            if (start_en) begin
                shreg_reg <= i_bit_vld ? first_word : '0;
                count_reg <= i_bit_vld ? CW'(1) : '0;
            end else if (shift_en) begin
                shreg_reg <= shift_word;
                if (last_bit) begin
                    sum_reg   <= shift_word;
                    count_reg <= '0;
                end else begin
                    count_reg <= count_reg + CW'(1);
                end
            end
            if (drop_en) begin
                ovf_reg <= 1'b1;
            end
        end
    end

`ifdef SERIAL_SUM_CARRY_EN
    logic cout_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cout_reg <= 1'b0;
        end else if (shift_en && last_bit) begin
            cout_reg <= i_carry;
        end
    end

    assign o_cout = cout_reg;
`else
    logic unused_carry;
    assign unused_carry = i_carry;
    assign o_cout       = 1'b0;
`endif

    assign o_sum = sum_reg;
    assign o_ovf = ovf_reg;

endmodule
